ula_serial_ctrl: RTL and testbench
==================================

// Module: ula_serial_ctrl
// PURPOSE
//  Nibble-serial sequencer that drives one 4-bit ula_74181 slice to compute a WIDTH-bit
//  operation over WIDTH/4 cycles. Each nibble's carry is registered into the next one.
//  Sits upstream (drives a/b/s/m/c_in) and downstream (consumes f/c_out/a_eq_b) of the ALU slice.
//  Exposes valid/ready handshakes on both operand and result sides.
// PARAMETERS
//  WIDTH   16   operand/result width in bits.
//               Must be a multiple of 4 and >= 4; NIB = WIDTH/4 nibbles.
// PORTS
//  clk          in   1      system clock, single clock domain (rising edge)
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      operand request valid
//  in_ready     out  1      sequencer can accept a request
//  op_a         in   WIDTH  operand A
//  op_b         in   WIDTH  operand B
//  op_s         in   4      function select {S3,S2,S1,S0}, passed to ALU unchanged
//  op_m         in   1      1 = logic mode, 0 = arithmetic mode
//  op_cin       in   1      carry-in for nibble 0 (active-high true carry)
//  alu_a        out  4      current nibble of A to the ALU slice
//  alu_b        out  4      current nibble of B to the ALU slice
//  alu_s        out  4      function select to the ALU slice
//  alu_m        out  1      mode to the ALU slice
//  alu_cin      out  1      carry-in to the ALU slice
//  alu_f        in   4      ALU result nibble (combinational from alu_*)
//  alu_c_out    in   1      ALU true carry-out (1 = carry, 0 = borrow)
//  alu_a_eq_b   in   1      ALU nibble-equality flag
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts the result
//  res_f        out  WIDTH  assembled result
//  res_cout     out  1      carry-out of the most significant nibble
//  res_eq       out  1      1 when op_a == op_b, formed as the AND over all nibbles
//  res_zero     out  1      1 when res_f == 0
// BEHAVIOUR
//  Reset:
//   - state = IDLE.
//   - in_ready = 1; out_valid = 0; res_f = 0; res_cout = 0; res_eq = 0; res_zero = 0.
//   - Operand registers = 0; nibble index = 0; carry register = 0; eq accumulator = 1.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   - in_ready = 1.
//   - On in_valid & in_ready, register op_a/op_b/op_s/op_m/op_cin and set idx = 0.
//   - Same edge: carry reg <= op_cin, eq acc <= 1, go to RUN.
//  RUN (in_ready = 0):
//   - alu_a = A_reg[4*idx +: 4], alu_b = B_reg[4*idx +: 4].
//   - alu_s = s_reg, alu_m = m_reg, alu_cin = carry reg.
//   - Each cycle: res_f[4*idx +: 4] <= alu_f, carry reg <= alu_c_out, eq acc <= eq acc & alu_a_eq_b.
//   - When idx == NIB-1: go to DONE on the same edge, registering res_cout/res_eq/res_zero
//     from the final values. Otherwise idx <= idx + 1.
//  DONE:
//   - out_valid = 1; res_* held stable while out_ready = 0.
//   - On out_ready: out_valid <= 0 and go to IDLE. A new request can be accepted one cycle later.
//  ALU-side outputs outside RUN: alu_a/alu_b/alu_cin = 0; alu_s/alu_m = s_reg/m_reg.
//  Timing and capture:
//   - The ALU path is combinational within one cycle; alu_* are driven from registers only.
//   - res_f is written nibble by nibble during RUN and is valid only when out_valid = 1.
//   - in_valid during RUN or DONE is ignored; operands are not sampled.
//  Latency:
//   - Accept edge at cycle 0; out_valid rises after the edge of cycle NIB.
//   - NIB+1 edges from accept to valid (WIDTH=16: 5).
//  Throughput: one operation every NIB+2 cycles minimum; no overlap.
//  Carry rules:
//   - In logic mode the ALU returns c_out = 0, so res_cout = 0.
//   - Carries between nibbles are still chained; this is harmless.
//  Width: idx counter is max(1, $clog2(NIB)) bits; no wrap, since the counter stops at NIB-1.
//  Reset mid-operation:
//   - rst in RUN or DONE aborts the operation with no result.
//   - All outputs return to reset values on that edge.
// TESTING (WIDTH=16)
//  1 m=0 s=1001 cin=0 a=0x00FF b=0x0001 -> res_f=0x0100 cout=0 eq=0 zero=0; out_valid 5 edges after accept
//  2 m=0 s=1001 cin=0 a=0xFFFF b=0x0001 -> res_f=0x0000 cout=1 zero=1 (carry ripples through all 4 nibbles)
//  3 m=0 s=0110 cin=1 a=0x1234 b=0x1234 -> res_f=0x0000 cout=1 eq=1; a=0x0001 b=0x0002 -> res_f=0xFFFF cout=0
//  4 m=1 s=0110 a=0xF0F0 b=0xFF00 -> res_f=0x0FF0 cout=0 eq=0
//  5 out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands applied
//    -> res_* stable, in_ready=0, new request not taken
//    -> after out_ready=1: IDLE for one cycle, then new request accepted
//  6 rst=1 one cycle after 2 nibbles in RUN -> next edge: out_valid=0, in_ready=1, res_f=0;
//    a new request then completes correctly

Source files
------------

// File: rtl/ula_serial_ctrl.sv
// Nibble-serial sequencer driving one 4-bit 74181-style ALU slice.
// A WIDTH-bit operation takes WIDTH/4 RUN cycles, with the carry registered between nibbles.
module ula_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_cin,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cin,
    input  logic [3:0]       alu_f,
    input  logic             alu_c_out,
    input  logic             alu_a_eq_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_cout,
    output logic             res_eq,
    output logic             res_zero
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg, b_reg, f_next;
    logic [3:0]       s_reg;
    logic             m_reg, carry, eq_acc;
    logic [IW-1:0]    idx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand nibbles and carry only reach the slice while RUN is active.
    assign alu_a   = (state == RUN) ? a_reg[4*idx +: 4] : 4'h0;
    assign alu_b   = (state == RUN) ? b_reg[4*idx +: 4] : 4'h0;
    assign alu_cin = (state == RUN) ? carry : 1'b0;
    assign alu_s   = s_reg;
    assign alu_m   = m_reg;

    // Result with the current nibble merged in, so the final flags see all nibbles.
    always_comb begin
        f_next = res_f;
        f_next[4*idx +: 4] = alu_f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= 4'h0;
            m_reg    <= 1'b0;
            carry    <= 1'b0;
            eq_acc   <= 1'b1;
            idx      <= '0;
            res_f    <= '0;
            res_cout <= 1'b0;
            res_eq   <= 1'b0;
            res_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg  <= op_a;
                    b_reg  <= op_b;
                    s_reg  <= op_s;
                    m_reg  <= op_m;
                    carry  <= op_cin;
                    eq_acc <= 1'b1;
                    idx    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    res_f  <= f_next;
                    carry  <= alu_c_out;
                    eq_acc <= eq_acc & alu_a_eq_b;
                    if (idx == LAST) begin
                        res_cout <= alu_c_out;
                        res_eq   <= eq_acc & alu_a_eq_b;
                        res_zero <= (f_next == '0);
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Directed bench for ula_serial_ctrl with a behavioural 74181 slice model on the ALU side.
module tb_ula_serial_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] op_a, op_b;
    logic [3:0]  op_s;
    logic        op_m, op_cin;
    logic [3:0]  alu_a, alu_b, alu_s, alu_f;
    logic        alu_m, alu_cin, alu_c_out, alu_a_eq_b;
    logic        out_valid, out_ready;
    logic [15:0] res_f;
    logic        res_cout, res_eq, res_zero;
    logic [4:0]  sum;
    int          checks = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    ula_serial_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_f(res_f), .res_cout(res_cout), .res_eq(res_eq), .res_zero(res_zero)
    );

    // Slice model: A plus B (1001), A minus B minus 1 (0110) in arithmetic, XOR/XNOR in logic.
    always_comb begin
        sum        = 5'd0;
        alu_f      = 4'h0;
        alu_c_out  = 1'b0;
        alu_a_eq_b = (alu_a == alu_b);
        if (alu_m) begin
            case (alu_s)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1001: alu_f = ~(alu_a ^ alu_b);
                default: alu_f = 4'h0;
            endcase
        end else begin
            case (alu_s)
                4'b1001: sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                4'b0110: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
                default: sum = {1'b0, alu_a} + {4'b0, alu_cin};
            endcase
            alu_f     = sum[3:0];
            alu_c_out = sum[4];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, hold it for the accept edge, then count edges until out_valid.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin, output int edges);
        in_valid = 1'b1; op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
        tick();
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({res_f, res_cout, res_eq, res_zero} !== 19'h0) begin errs++; $display("FAIL reset_res got %h %b%b%b want 0", res_f, res_cout, res_eq, res_zero); end
        checks++; if ({alu_a, alu_b, alu_cin} !== 9'h0) begin errs++; $display("FAIL reset_alu got %h %h %b want 0", alu_a, alu_b, alu_cin); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int e;
        issue(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, e);
        checks++; if (e !== 5) begin errs++; $display("FAIL add_latency got %0d want 5", e); end
        checks++; if (res_f !== 16'h0100) begin errs++; $display("FAIL add_f got %h want 0100", res_f); end
        checks++; if ({res_cout, res_eq, res_zero} !== 3'b000) begin errs++; $display("FAIL add_flags got %b want 000", {res_cout, res_eq, res_zero}); end
        consume();
        issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, e);
        checks++; if (res_f !== 16'h0000) begin errs++; $display("FAIL ripple_f got %h want 0000", res_f); end
        checks++; if ({res_cout, res_zero} !== 2'b11) begin errs++; $display("FAIL ripple_flags got %b want 11", {res_cout, res_zero}); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL consume got v=%b r=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_sub();
        int e;
        issue(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, e);
        checks++; if (res_f !== 16'h0000) begin errs++; $display("FAIL sub_eq_f got %h want 0000", res_f); end
        checks++; if ({res_cout, res_eq, res_zero} !== 3'b111) begin errs++; $display("FAIL sub_eq_flags got %b want 111", {res_cout, res_eq, res_zero}); end
        consume();
        issue(16'h0001, 16'h0002, 4'b0110, 1'b0, 1'b1, e);
        checks++; if (res_f !== 16'hFFFF) begin errs++; $display("FAIL sub_borrow_f got %h want ffff", res_f); end
        checks++; if ({res_cout, res_eq, res_zero} !== 3'b000) begin errs++; $display("FAIL sub_borrow_flags got %b want 000", {res_cout, res_eq, res_zero}); end
        consume();
    endtask

    task automatic test_logic();
        int e;
        issue(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, e);
        checks++; if (res_f !== 16'h0FF0) begin errs++; $display("FAIL xor_f got %h want 0ff0", res_f); end
        checks++; if ({res_cout, res_eq, res_zero} !== 3'b000) begin errs++; $display("FAIL xor_flags got %b want 000", {res_cout, res_eq, res_zero}); end
        checks++; if (alu_m !== 1'b1 || alu_s !== 4'b0110 || alu_a !== 4'h0) begin errs++; $display("FAIL done_alu got m=%b s=%b a=%h want 1 0110 0", alu_m, alu_s, alu_a); end
        consume();
    endtask

    task automatic test_back_to_back();
        int e;
        issue(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, e);
        in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (res_f !== 16'h0100 || out_valid !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL hold_%0d got f=%h v=%b r=%b want 0100 1 0", i, res_f, out_valid, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL idle_gap got r=%b v=%b want 1 0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL new_accept got r=%b want 0", in_ready); end
        e = 1;
        while (!out_valid && e < 20) begin tick(); e++; end
        checks++; if (e !== 5 || res_f !== 16'h3333) begin errs++; $display("FAIL new_result got lat=%0d f=%h want 5 3333", e, res_f); end
        consume();
    endtask

    task automatic test_reset_mid();
        int e;
        in_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'h0001; op_s = 4'b1001; op_m = 1'b0; op_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL midrst_hs got v=%b r=%b want 0 1", out_valid, in_ready); end
        checks++; if (res_f !== 16'h0000 || alu_a !== 4'h0 || res_cout !== 1'b0) begin errs++; $display("FAIL midrst_res got f=%h a=%h c=%b want 0", res_f, alu_a, res_cout); end
        issue(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, e);
        checks++; if (e !== 5 || res_f !== 16'h1011 || res_cout !== 1'b0) begin errs++; $display("FAIL midrst_after got lat=%0d f=%h c=%b want 5 1011 0", e, res_f, res_cout); end
        consume();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
